// File: rtl/wb_coproc_master.sv
// wb_coproc_master: Wishbone classic master feeding a coprocessor slave (opa@0x00, opb@0x04, results 0x08..0x14) with an operand write cache; cmd/rsp valid-ready ports, registered wb_* outputs, rsp_err on access timeout
module wb_coproc_master #(
  parameter int TIMEOUT_CYC = 16,
  parameter bit SKIP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_opa,
  input  logic [31:0] cmd_opb,
  input  logic [1:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, WR_A, GAP, WR_B, RD, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d, cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [31:0] rsp_data_q, rsp_data_d, wb_dat_q, wb_dat_d;
  logic [1:0] op_q, op_d;
  logic [4:0] wb_adr_q, wb_adr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic need_b_q, need_b_d, va_q, va_d, vb_q, vb_d, rsp_err_q, rsp_err_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic wb_we_q, wb_we_d, wb_stb_q, wb_stb_d;
  logic busy, timeout, na, nb;
  assign busy = state_q == WR_A || state_q == WR_B || state_q == RD;
  // The counter restarts whenever an access starts because every access is entered from a non-access state
  assign timeout = busy && !wb_ack_i && (cnt_q + CW'(1)) == CW'(TIMEOUT_CYC);
  assign na = !(SKIP_EN && va_q && cache_a_q == cmd_opa);
  assign nb = !(SKIP_EN && vb_q && cache_b_q == cmd_opb);
  always_comb begin
    state_d = state_q;
    opa_d = opa_q;
    opb_d = opb_q;
    op_d = op_q;
    need_b_d = need_b_q;
    cache_a_d = cache_a_q;
    cache_b_d = cache_b_q;
    va_d = va_q;
    vb_d = vb_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    cnt_d = busy && !wb_ack_i ? cnt_q + CW'(1) : '0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        opa_d = cmd_opa;
        opb_d = cmd_opb;
        op_d = cmd_op;
        need_b_d = nb;
        state_d = na ? WR_A : nb ? WR_B : RD;
      end
      WR_A, WR_B, RD: if (wb_ack_i) begin
        if (state_q == WR_A) begin
          cache_a_d = opa_q;
          va_d = 1'b1;
          state_d = GAP;
        end else if (state_q == WR_B) begin
          cache_b_d = opb_q;
          vb_d = 1'b1;
          need_b_d = 1'b0;
          state_d = GAP;
        end else begin
          rsp_data_d = wb_dat_i;
          rsp_err_d = 1'b0;
          state_d = RESP;
        end
      end else if (timeout) begin
        va_d = 1'b0;
        vb_d = 1'b0;
        rsp_data_d = '0;
        rsp_err_d = 1'b1;
        state_d = RESP;
      end
      GAP: state_d = need_b_q ? WR_B : RD;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Bus outputs are decoded from the next state so they change on the same edge as the state
    wb_stb_d = state_d == WR_A || state_d == WR_B || state_d == RD;
    wb_we_d = state_d == WR_A || state_d == WR_B;
    wb_adr_d = state_d == WR_A ? 5'h00 : state_d == WR_B ? 5'h04 : state_d == RD ? 5'h08 + {1'b0, op_d, 2'b00} : 5'h00;
    wb_dat_d = state_d == WR_A ? opa_d : state_d == WR_B ? opb_d : 32'h0;
    cmd_ready_d = state_d == IDLE;
    rsp_valid_d = state_d == RESP;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q <= '0;
      opb_q <= '0;
      op_q <= '0;
      need_b_q <= 1'b0;
      cache_a_q <= '0;
      cache_b_q <= '0;
      va_q <= 1'b0;
      vb_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      cnt_q <= '0;
      wb_stb_q <= 1'b0;
      wb_we_q <= 1'b0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      op_q <= op_d;
      need_b_q <= need_b_d;
      cache_a_q <= cache_a_d;
      cache_b_q <= cache_b_d;
      va_q <= va_d;
      vb_q <= vb_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      cnt_q <= cnt_d;
      wb_stb_q <= wb_stb_d;
      wb_we_q <= wb_we_d;
      wb_adr_q <= wb_adr_d;
      wb_dat_q <= wb_dat_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign wb_adr_o = wb_adr_q;
  assign wb_dat_o = wb_dat_q;
  assign wb_we_o = wb_we_q;
  assign wb_stb_o = wb_stb_q;
  assign wb_cyc_o = wb_stb_q;
endmodule

// File: tb/tb_wb_coproc_master.sv
// tb_wb_coproc_master: directed self-checking bench with a registered-ack coprocessor slave model
module tb_wb_coproc_master;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] cmd_opa = '0, cmd_opb = '0, rsp_data, wb_dat_o, wb_dat_i;
  logic [1:0] cmd_op = '0;
  logic [4:0] wb_adr_o;
  logic wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
  logic ack_en = 1'b1, stb_prev = 1'b0;
  logic [31:0] rega = '0, regb = '0;
  logic [23:0] trace = '0;
  int n_hi = 0, checks = 0, errors = 0;
  wb_coproc_master #(.TIMEOUT_CYC(16), .SKIP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i));
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) begin
    if (rst) wb_ack_i <= 1'b0;
    else begin
      wb_ack_i <= ack_en && wb_cyc_o && wb_stb_o && !wb_ack_i;
      if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i) begin
        if (wb_adr_o == 5'h00) rega <= wb_dat_o;
        if (wb_adr_o == 5'h04) regb <= wb_dat_o;
      end
    end
  end
  assign wb_dat_i = wb_adr_o == 5'h08 ? rega >> regb[4:0] : wb_adr_o == 5'h0C ? rega & regb :
                    wb_adr_o == 5'h10 ? rega | regb : wb_adr_o == 5'h14 ? rega ^ regb :
                    wb_adr_o == 5'h04 ? regb : rega;
  always @(negedge clk) begin
    if (wb_stb_o && !stb_prev) trace = {trace[17:0], 1'b1, wb_adr_o};
    if (wb_stb_o) n_hi++;
    stb_prev = wb_stb_o;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                         input logic [23:0] exp_tr, input int exp_hi, input int hold);
    int n;
    logic bad;
    logic [31:0] d0;
    @(negedge clk);
    cmd_opa = a;
    cmd_opb = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    trace = '0;
    n_hi = 0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", n, exp_lat);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", rsp_err, exp_e);
    bad = 1'b0;
    d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      bad |= !rsp_valid || rsp_data !== d0 || cmd_ready || wb_stb_o || wb_cyc_o;
    end
    cmd_valid = 1'b0;
    if (hold > 0) chk("hold_stable", bad, 0);
    chk("bus_trace", trace, exp_tr);
    chk("stb_high_cycles", n_hi, exp_hi);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("cmd_ready_after_rsp", cmd_ready, 1);
    chk("rsp_valid_drop", rsp_valid, 0);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    chk("rst_rsp", {rsp_err, rsp_data}, 0);
    rst = 1'b0;
    run_cmd(32'hF0F0_0000, 32'h4, 2'd0, 32'h0F0F_0000, 1'b0, 8, 24'h020928, 6, 0);
    run_cmd(32'hF0F0_0000, 32'h4, 2'd3, 32'hF0F0_0004, 1'b0, 2, 24'h000034, 2, 0);
    run_cmd(32'hF0F0_0000, 32'hFF, 2'd1, 32'h0, 1'b0, 5, 24'h00092C, 4, 0);
    ack_en = 1'b0;
    run_cmd(32'hAAAA_0000, 32'hFF, 2'd0, 32'h0, 1'b1, 16, 24'h000020, 16, 0);
    ack_en = 1'b1;
    run_cmd(32'hF0F0_0000, 32'hFF, 2'd2, 32'hF0F0_00FF, 1'b0, 8, 24'h020930, 6, 0);
    run_cmd(32'hF0F0_0000, 32'hFF, 2'd3, 32'hF0F0_00FF, 1'b0, 2, 24'h000034, 2, 10);
    @(negedge clk);
    cmd_opa = 32'h1234_5678;
    cmd_opb = 32'hF;
    cmd_op = 2'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (!(wb_stb_o && wb_adr_o == 5'h04) && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("reach_wr_b", n, 3);
    #2 rst = 1'b1;
    #1 chk("async_rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release_ready", cmd_ready, 1);
    run_cmd(32'h1234_5678, 32'hF, 2'd3, 32'h1234_5677, 1'b0, 8, 24'h020934, 6, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
